// File: rtl/xor_cipher_pkg.sv
// Shared types and helpers for the serial XOR stream cipher.
// XOR_KEY_ROTATE_EN (optional) selects the rolling-key mode in xor_stream_cipher.
package xor_cipher_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ENCRYPT   = 2'd1,
        SHIFT_OUT = 2'd2
    } state_t;

    // Widest key the rotate helper supports.
    localparam int ROTL_MAX = 256;

    // Counter width able to hold the value n itself (saturating counters).
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Rotate the low w bits of v left by s (0 <= s < w); bits above w are cleared.
    function automatic logic [ROTL_MAX-1:0] rotl(input logic [ROTL_MAX-1:0] v,
                                                 input int w, input int s);
        logic [ROTL_MAX-1:0] mask;
        mask = (ROTL_MAX'(1) << w) - ROTL_MAX'(1);
        if (s == 0) begin
            return v & mask;
        end
        return ((v << s) | (v >> (w - s))) & mask;
    endfunction

endpackage

// File: rtl/xor_stream_cipher_piso.sv
// Parallel-in serial-out stage: loads W bits, shifts them out MSB first with a valid flag.
module cipher_piso
    import xor_cipher_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_ena,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic         o_serial,
    output logic         o_last
);
    localparam int CNT_W = cnt_w(W);

    logic [W-1:0]     r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_ena) begin
            if (i_load) begin
                r_sr    <= i_data;
                r_cnt   <= '0;
                r_valid <= 1'b1;
            end else if (r_valid) begin
                r_sr <= r_sr << 1;
                if (o_last) begin
                    r_valid <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_serial = r_valid & r_sr[W-1];
    assign o_last   = r_valid && (r_cnt == CNT_W'(W - 1));

endmodule

// File: rtl/xor_stream_cipher.sv
// Serial XOR cipher: key and message share data_in, ciphertext leaves MSB first on dout.
// Define XOR_KEY_ROTATE_EN to rotate the key left by (chunk index mod KEY_SIZE) per chunk.
module xor_stream_cipher
    import xor_cipher_pkg::*;
#(
    parameter int KEY_SIZE = 8,
    parameter int MSG_SIZE = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic data_in,
    input  logic key_load,
    input  logic msg_load,
    output logic key_ready,
    output logic busy,
    output logic dout_valid,
    output logic dout,
    output logic enc_done
);
    localparam int NCHUNK = MSG_SIZE / KEY_SIZE;
    localparam int KCNT_W = cnt_w(KEY_SIZE);
    localparam int MCNT_W = cnt_w(MSG_SIZE);
    localparam int CIDX_W = cnt_w(NCHUNK);
    localparam logic [MSG_SIZE-1:0] CHUNK_MASK = MSG_SIZE'({KEY_SIZE{1'b1}});

    state_t              r_state;
    logic [KEY_SIZE-1:0] r_key;
    logic [KCNT_W-1:0]   r_kcnt;
    logic                r_kl_d;
    logic [MSG_SIZE-1:0] r_msg;
    logic [MCNT_W-1:0]   r_mcnt;
    logic [CIDX_W-1:0]   r_idx;
    logic [MSG_SIZE-1:0] r_ct;
    logic                r_enc_done;

    logic                w_busy;
    logic                w_key_ready;
    logic                w_msg_full;
    logic                w_last_chunk;
    logic                w_piso_load;
    logic                w_piso_last;
    logic [KEY_SIZE-1:0] w_key_i;
    logic [KEY_SIZE-1:0] w_chunk;
    logic [MSG_SIZE-1:0] w_ct_next;
    int                  w_shift;

    assign w_busy       = (r_state != IDLE);
    assign w_key_ready  = (r_kcnt == KCNT_W'(KEY_SIZE));
    assign w_msg_full   = (r_mcnt == MCNT_W'(MSG_SIZE));
    assign w_last_chunk = (r_idx == CIDX_W'(NCHUNK - 1));
    assign w_piso_load  = (r_state == ENCRYPT) && w_last_chunk;

`ifdef XOR_KEY_ROTATE_EN
    assign w_key_i = KEY_SIZE'(rotl(ROTL_MAX'(r_key), KEY_SIZE, int'(r_idx) % KEY_SIZE));
`else
    assign w_key_i = r_key;
`endif

    // Chunk 0 is the most significant KEY_SIZE bits of the message.
    always_comb begin
        w_shift   = MSG_SIZE - KEY_SIZE - int'(r_idx) * KEY_SIZE;
        w_chunk   = KEY_SIZE'(r_msg >> w_shift) ^ w_key_i;
        w_ct_next = (r_ct & ~(CHUNK_MASK << w_shift)) | (MSG_SIZE'(w_chunk) << w_shift);
    end

    // Key loader runs beside the FSM; a rising key_load restarts the key.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key  <= '0;
            r_kcnt <= '0;
            r_kl_d <= 1'b0;
        end else if (ena) begin
            r_kl_d <= key_load;
            if (key_load && !w_busy) begin
                if (!r_kl_d) begin
                    r_key  <= KEY_SIZE'(data_in);
                    r_kcnt <= KCNT_W'(1);
                end else begin
                    r_key <= {r_key[KEY_SIZE-2:0], data_in};
                    if (!w_key_ready) begin
                        r_kcnt <= r_kcnt + KCNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_msg      <= '0;
            r_mcnt     <= '0;
            r_idx      <= '0;
            r_ct       <= '0;
            r_enc_done <= 1'b0;
        end else if (ena) begin
            r_enc_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (msg_load && !key_load && !w_msg_full) begin
                        r_msg  <= {r_msg[MSG_SIZE-2:0], data_in};
                        r_mcnt <= r_mcnt + MCNT_W'(1);
                    end
                    if (w_msg_full && w_key_ready) begin
                        r_state <= ENCRYPT;
                        r_idx   <= '0;
                    end
                end
                ENCRYPT: begin
                    r_ct <= w_ct_next;
                    if (w_last_chunk) begin
                        r_idx   <= '0;
                        r_state <= SHIFT_OUT;
                    end else begin
                        r_idx <= r_idx + CIDX_W'(1);
                    end
                end
                SHIFT_OUT: begin
                    if (w_piso_last) begin
                        r_state    <= IDLE;
                        r_enc_done <= 1'b1;
                        r_mcnt     <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // dout_valid is a push-only strobe: no back-pressure, one ciphertext bit per enabled cycle.
    cipher_piso #(.W(MSG_SIZE)) u_piso (
        .clk      (clk),
        .rst      (rst),
        .i_ena    (ena),
        .i_load   (w_piso_load),
        .i_data   (w_ct_next),
        .o_valid  (dout_valid),
        .o_serial (dout),
        .o_last   (w_piso_last)
    );

    assign key_ready = w_key_ready;
    assign busy      = w_busy;
    assign enc_done  = r_enc_done;

endmodule
